// File: rtl/universal_register.sv
// universal_register: WIDTH-bit enable-gated register with load, shift,
// rotate, increment and decrement modes, a registered carry/shift-out flag
// and a combinational zero flag.
module universal_register #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic             C,
    output logic             Z
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_e;

    localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             c_q, c_d;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;

    // Next-state selection; anything other than a legal enabled mode holds.
    always_comb begin
        // NOTE: defaults first so every path assigns q_d/c_d and no latch is inferred.
        q_d      = q_q;
        c_d      = c_q;
        // Widened by one bit so the carry/borrow falls out of the top bit.
        sum_ext  = {1'b0, q_q} + ONE_EXT;
        diff_ext = {1'b0, q_q} - ONE_EXT;
        if (E) begin
            case (mode)
                MODE_HOLD: begin
                    q_d = q_q;
                    c_d = c_q;
                end
                MODE_LOAD: begin
                    q_d = D;
                    c_d = 1'b0;
                end
                MODE_SHL: begin
                    q_d = {q_q[WIDTH-2:0], sin};
                    c_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d = {sin, q_q[WIDTH-1:1]};
                    c_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    c_d = q_q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d = {q_q[0], q_q[WIDTH-1:1]};
                    c_d = q_q[0];
                end
                MODE_INC: begin
                    q_d = sum_ext[WIDTH-1:0];
                    c_d = sum_ext[WIDTH];
                end
                MODE_DEC: begin
                    q_d = diff_ext[WIDTH-1:0];
                    c_d = diff_ext[WIDTH];
                end
                default: begin
                    q_d = q_q;
                    c_d = c_q;
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= RESET_VALUE;
            c_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            q_q <= q_d;
            c_q <= c_d;
        end
    end

    assign Q = q_q;
    assign C = c_q;
    assign Z = (q_q == '0);

endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against an arithmetic model.
module tb_universal_register;

    logic       clk;
    logic       reset;
    logic       E;
    logic [2:0] mode;
    logic [7:0] D;
    logic       sin;
    logic [7:0] Q;
    logic       C;
    logic       Z;

    int total = 0;
    int bad   = 0;

    // Reference state, computed with plain integer arithmetic.
    int m_q = 0;
    int m_c = 0;

    universal_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk  (clk),
        .reset(reset),
        .E    (E),
        .mode (mode),
        .D    (D),
        .sin  (sin),
        .Q    (Q),
        .C    (C),
        .Z    (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: reset clears, enabled edges apply the mode rule.
    always @(posedge clk or negedge reset) begin
        int q;
        int s;
        q = m_q;
        s = int'(sin);
        if (!reset) begin
            m_q = 0;
            m_c = 0;
        end else if (E === 1'b1 && !$isunknown(mode)) begin
            case (int'(mode))
                1: begin m_q = int'(D);                  m_c = 0;              end
                2: begin m_q = (q * 2) % 256 + s;         m_c = (q >= 128);     end
                3: begin m_q = q / 2 + s * 128;           m_c = q % 2;          end
                4: begin m_q = (q * 2) % 256 + q / 128;   m_c = (q >= 128);     end
                5: begin m_q = q / 2 + (q % 2) * 128;     m_c = q % 2;          end
                6: begin m_q = (q + 1) % 256;             m_c = (q == 255);     end
                7: begin m_q = (q + 255) % 256;           m_c = (q == 0);       end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        check("model_q", int'(Q), m_q);
        check("model_c", int'(C), m_c);
        check("model_z", int'(Z), int'(m_q == 0));
    end

    // Drive one operation, wait for its edge, settle just after it.
    task automatic cyc(input logic e, input logic [2:0] m, input logic [7:0] d, input logic s);
        E = e; mode = m; D = d; sin = s;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_qc(input string name, input int q, input int c);
        check({name, "_q"}, int'(Q), q);
        check({name, "_c"}, int'(C), c);
        check({name, "_z"}, int'(Z), int'(q == 0));
    endtask

    initial begin
        reset = 1'b0; E = 1'b1; mode = 3'b001; D = 8'hA5; sin = 1'b0;

        // Reset held across two edges with a load pending.
        repeat (2) begin
            @(posedge clk);
            #1;
            expect_qc("reset_hold", 8'h00, 0);
        end

        // Enable gating.
        reset = 1'b1; E = 1'b0;
        @(posedge clk); #1;
        check("gate_off_q", int'(Q), 8'h00);
        @(negedge clk); E = 1'b1; #1;
        check("gate_pre_edge_q", int'(Q), 8'h00);
        @(posedge clk); #1;
        expect_qc("gate_load", 8'hA5, 0);

        // Shifts and hold.
        cyc(1'b1, 3'b010, 8'h00, 1'b1); expect_qc("shl",  8'h4B, 1);
        cyc(1'b1, 3'b011, 8'h00, 1'b0); expect_qc("shr",  8'h25, 1);
        cyc(1'b1, 3'b000, 8'h00, 1'b0); expect_qc("hold", 8'h25, 1);

        // Rotates.
        cyc(1'b1, 3'b001, 8'h81, 1'b0); expect_qc("load81", 8'h81, 0);
        cyc(1'b1, 3'b100, 8'h00, 1'b0); expect_qc("rol",    8'h03, 1);
        cyc(1'b1, 3'b101, 8'h00, 1'b0); expect_qc("ror",    8'h81, 1);

        // Counting with wrap and borrow.
        cyc(1'b1, 3'b001, 8'hFF, 1'b0); expect_qc("loadff",   8'hFF, 0);
        cyc(1'b1, 3'b110, 8'h00, 1'b0); expect_qc("inc_wrap", 8'h00, 1);
        cyc(1'b1, 3'b111, 8'h00, 1'b0); expect_qc("dec_borrow", 8'hFF, 1);
        cyc(1'b1, 3'b001, 8'h01, 1'b0);
        cyc(1'b1, 3'b111, 8'h00, 1'b0); expect_qc("dec_to_zero", 8'h00, 0);

        // Mid-operation asynchronous reset.
        cyc(1'b1, 3'b001, 8'h5A, 1'b0);
        cyc(1'b1, 3'b010, 8'h00, 1'b0); expect_qc("shl_a", 8'hB4, 0);
        cyc(1'b1, 3'b010, 8'h00, 1'b0); expect_qc("shl_b", 8'h68, 1);
        #2 reset = 1'b0;
        #1 expect_qc("async_reset", 8'h00, 0);
        #1 reset = 1'b1;
        cyc(1'b1, 3'b110, 8'h00, 1'b0); expect_qc("inc_after_reset", 8'h01, 0);

        // Randomized operation, with occasional mid-cycle reset pulses.
        for (int i = 0; i < 3000; i++) begin
            E    = ($urandom_range(0, 7) != 0);
            mode = 3'($urandom_range(0, 7));
            D    = 8'($urandom_range(0, 255));
            sin  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b0;
                #1 expect_qc("rand_reset", 8'h00, 0);
                #1 reset = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/universal_register.md
# universal_register

Parametrised, enable-gated, multi-mode register: the generalised successor to the single-bit D/enable storage element. It provides a WIDTH-bit register with parallel load, shift, rotate, increment and decrement modes. A registered carry/shift-out flag and a zero flag accompany the register. It serves as the standard state-holding element for datapath registers, shift chains and counters in the CDA3102 design library.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- RESET_VALUE, 0, value loaded into Q on reset; WIDTH bits.

Ports:
- clk  input  1  clock; all updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- E  input  1  enable; 0 = hold regardless of mode.
- mode  input  3  operation select (see Operation).
- D  input  WIDTH  parallel load data.
- sin  input  1  serial input for shift modes.
- Q  output  WIDTH  register contents.
- C  output  1  registered carry / borrow / shifted-out bit of the last enabled operation.
- Z  output  1  combinational; 1 when Q == 0.

## Operation
- reset low: Q = RESET_VALUE, C = 0 immediately, independent of clk; Z follows Q. All other inputs are ignored while reset is low.
- E = 0 at a rising edge: Q and C hold, whatever the mode.
- E = 1 at a rising edge, by mode:
  - 000 hold: Q and C unchanged.
  - 001 load: Q <= D; C <= 0.
  - 010 shift left: Q <= {Q[WIDTH-2:0], sin}; C <= Q[WIDTH-1].
  - 011 shift right: Q <= {sin, Q[WIDTH-1:1]}; C <= Q[0].
  - 100 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; C <= Q[WIDTH-1].
  - 101 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}; C <= Q[0].
  - 110 increment: Q <= Q + 1, modulo 2^WIDTH; C <= 1 only when Q was all-ones (wrap), else 0.
  - 111 decrement: Q <= Q - 1, modulo 2^WIDTH; C <= 1 only when Q was 0 (borrow), else 0.
- Arithmetic is unsigned, WIDTH bits; the carry is captured in C and never widens Q.
- C always reflects the pre-edge Q value of the operation that produced it.
- X/Z on mode while E = 1 is a bench error; the RTL holds Q and C in that case.

## Timing
- Latency: 1 cycle. Q and C update at the rising edge on which E = 1 is sampled, and are valid before the next edge.
- Z is combinational from Q, so it changes in the same delta as Q.
- Reset assertion is asynchronous and takes effect mid-cycle.
- Reset deassertion: the first rising edge with reset high performs the selected operation. Deassertion coincident with a rising edge performs no operation on that edge.
- Reset mid-operation, e.g. during a shift sequence: contents are discarded and Q = RESET_VALUE. Operation resumes from RESET_VALUE, with no partial state retained.
- No falling-edge activity: inputs changing while clk is low or high have no effect until the next rising edge.
- Simultaneous E/mode/D changes at an edge: values sampled at the edge win; setup to the edge is the caller's responsibility.

## Test plan
All scenarios use WIDTH = 8 and RESET_VALUE = 0.
1. Reset: with clk low, drive reset = 0, E = 1, mode = 001, D = 0xA5, and hold across two rising edges -> Q = 0x00, C = 0, Z = 1 throughout. The values are set before the first edge.
2. Enable gating:
   - reset = 1, E = 0, mode = 001, D = 0xA5, rising edge -> Q = 0x00.
   - Set E = 1 at the falling edge -> Q stays 0x00 until the next rising edge, then Q = 0xA5, C = 0, Z = 0.
3. Shifts:
   - From Q = 0xA5, mode = 010, sin = 1, edge -> Q = 0x4B, C = 1.
   - Then mode = 011, sin = 0, edge -> Q = 0x25, C = 1.
   - Then mode = 000, edge -> Q = 0x25, C = 1 (hold).
4. Rotates:
   - Load 0x81, then mode = 100, edge -> Q = 0x03, C = 1.
   - Then mode = 101, edge -> Q = 0x81, C = 1.
5. Counting:
   - Load 0xFF, mode = 110, edge -> Q = 0x00, C = 1, Z = 1.
   - Then mode = 111, edge -> Q = 0xFF, C = 1.
   - Load 0x01, mode = 111, edge -> Q = 0x00, C = 0, Z = 1.
6. Mid-operation reset:
   - Load 0x5A, then shift left for two edges (Q = 0x68 with sin = 0).
   - Pulse reset low between edges -> Q = 0x00 and C = 0 immediately.
   - Release reset, then increment on the next edge -> Q = 0x01.
